// File: rtl/regfile_cmd_seq.sv
// regfile_cmd_seq: debounced button to timed data-bus/strobe sequence for a 16x4 register file
module regfile_cmd_seq #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STROBE_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       op,
  input  logic [3:0] addr_a,
  input  logic [3:0] addr_b,
  input  logic [3:0] wdata,
  output logic [3:0] sw_out,
  output logic       strb_rr1,
  output logic       strb_rr2,
  output logic       strb_wr,
  output logic       strb_wd,
  output logic       strb_we,
  output logic       busy,
  output logic       done
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(STROBE_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_FIN} state_t;
  logic [1:0] sync;
  logic db;
  logic [DW-1:0] dcnt;
  logic press;
  state_t st, st_n;
  logic [1:0] step, step_n;
  logic [CW-1:0] scnt, scnt_n;
  logic op_q, op_n;
  logic [3:0] a_q, a_n, b_q, b_n, d_q, d_n;
  logic [3:0] sw_n;
  logic [4:0] strb_n, sel;
  logic act;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      db   <= 1'b0;
      dcnt <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == db) dcnt <= '0;
      else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db   <= sync[1];
        dcnt <= '0;
      end else dcnt <= dcnt + 1'b1;
    end
  // press fires in the same cycle the debounced level rises
  assign press = sync[1] & ~db & (dcnt == DW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st     <= S_IDLE;
      step   <= '0;
      scnt   <= '0;
      op_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      sw_out <= '0;
      {strb_we, strb_wd, strb_wr, strb_rr2, strb_rr1} <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      st     <= st_n;
      step   <= step_n;
      scnt   <= scnt_n;
      op_q   <= op_n;
      a_q    <= a_n;
      b_q    <= b_n;
      d_q    <= d_n;
      sw_out <= sw_n;
      {strb_we, strb_wd, strb_wr, strb_rr2, strb_rr1} <= strb_n;
      busy   <= act;
      done   <= st_n == S_FIN;
    end
  always_comb begin
    st_n   = st;
    step_n = step;
    scnt_n = scnt;
    op_n   = op_q;
    a_n    = a_q;
    b_n    = b_q;
    d_n    = d_q;
    case (st)
      S_IDLE, S_FIN: begin
        st_n = press ? S_SETUP : S_IDLE;
        if (press) begin
          step_n = '0;
          op_n   = op;
          a_n    = addr_a;
          b_n    = addr_b;
          d_n    = wdata;
        end
      end
      S_SETUP: begin
        st_n   = S_STROBE;
        scnt_n = '0;
      end
      S_STROBE: begin
        st_n   = (scnt == CW'(STROBE_CYCLES - 1)) ? S_HOLD : S_STROBE;
        scnt_n = (scnt == CW'(STROBE_CYCLES - 1)) ? scnt : scnt + 1'b1;
      end
      S_HOLD: begin
        st_n   = (step == (op_q ? 2'd3 : 2'd1)) ? S_FIN : S_SETUP;
        step_n = (step == (op_q ? 2'd3 : 2'd1)) ? step : step + 1'b1;
      end
      default: st_n = S_IDLE;
    endcase
  end
  // outputs decoded from next state so every output is a flop
  always_comb begin
    act    = st_n == S_SETUP || st_n == S_STROBE || st_n == S_HOLD;
    sel    = op_n ? (step_n == 2'd0 ? 5'b00100 : step_n == 2'd1 ? 5'b01000 : 5'b10000)
                  : (step_n == 2'd0 ? 5'b00001 : 5'b00010);
    sw_n   = !act ? 4'h0
           : op_n ? (step_n == 2'd0 ? a_n : step_n == 2'd1 ? d_n : step_n == 2'd2 ? 4'hF : 4'h0)
                  : (step_n == 2'd0 ? a_n : b_n);
    strb_n = st_n == S_STROBE ? sel : 5'b0;
  end
endmodule

// File: tb/tb_regfile_cmd_seq.sv
// tb_regfile_cmd_seq: scoreboard bench with a strobe-level register-file model
module tb_regfile_cmd_seq;
  localparam int DB = 4, SC = 2;
  logic clk = 0, rst_n = 0, btn = 0, op = 0;
  logic [3:0] addr_a = 0, addr_b = 0, wdata = 0;
  logic [3:0] sw_out;
  logic strb_rr1, strb_rr2, strb_wr, strb_wd, strb_we, busy, done;

  regfile_cmd_seq #(.DEBOUNCE_CYCLES(DB), .STROBE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .op(op), .addr_a(addr_a), .addr_b(addr_b),
    .wdata(wdata), .sw_out(sw_out), .strb_rr1(strb_rr1), .strb_rr2(strb_rr2),
    .strb_wr(strb_wr), .strb_wd(strb_wd), .strb_we(strb_we), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {int kind; logic [3:0] val;} ev_t;
  ev_t exp_q[$];
  int exp_done[$];
  int checks = 0, errors = 0;
  int n_done = 0, cyc = 0, busy_rise = 0, width = 0;
  logic [3:0] rf_ref[16], rf_mon[16];
  logic [4:0] prev_s = 0, s;
  logic [3:0] prev_sw = 0, wa = 0, wd = 0;
  logic prev_busy = 0;
  ev_t e;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  function automatic ev_t mk(int k, logic [3:0] v);
    mk.kind = k;
    mk.val  = v;
  endfunction

  // monitor: kinds 0..4 = rr1, rr2, wr, wd, we
  always @(negedge clk) begin
    cyc++;
    s = {strb_we, strb_wd, strb_wr, strb_rr2, strb_rr1};
    if (!rst_n) begin
      prev_s = 0;
      prev_busy = 0;
      width = 0;
    end else begin
      if (s != 0) begin
        chk("one_hot", $countones(s), 1);
        chk("strobe_while_busy", busy, 1);
      end
      if (prev_s != 0) chk("sw_stable", sw_out, prev_sw);
      if (s != 0 && prev_s == 0) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", s, 0);
        else begin
          e = exp_q.pop_front();
          chk("strobe_kind", $clog2(s), e.kind);
          chk("strobe_val", sw_out, e.val);
        end
        width = 1;
      end else if (s != 0) width++;
      if (s == 0 && prev_s != 0) chk("strobe_width", width, SC);
      if (strb_wr) wa = sw_out;
      if (strb_wd) wd = sw_out;
      if (strb_we && sw_out == 4'hF) rf_mon[wa] = wd;
      if (busy && !prev_busy) busy_rise = cyc;
      if (done) begin
        chk("done_busy_low", busy, 0);
        if (exp_done.size() == 0) chk("unexpected_done", done, 0);
        else chk("done_latency", cyc - busy_rise, exp_done.pop_front() * (SC + 2));
        n_done++;
      end
      prev_s = s;
      prev_busy = busy;
    end
    prev_sw = sw_out;
  end

  task automatic expect_cmd(logic o, logic [3:0] a, logic [3:0] b, logic [3:0] d);
    if (!o) begin
      exp_q.push_back(mk(0, a));
      exp_q.push_back(mk(1, b));
      exp_done.push_back(2);
    end else begin
      exp_q.push_back(mk(2, a));
      exp_q.push_back(mk(3, d));
      exp_q.push_back(mk(4, 4'hF));
      exp_q.push_back(mk(4, 4'h0));
      exp_done.push_back(4);
      rf_ref[a] = d;
    end
  endtask

  task automatic press(int hold);
    @(posedge clk); #1 btn = 1;
    repeat (hold) @(posedge clk);
    #1 btn = 0;
    repeat (10) @(posedge clk);
  endtask

  task automatic wait_done(int n0);
    int t = 0;
    while (n_done <= n0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk("done_seen", int'(n_done > n0), 1);
  endtask

  task automatic run_cmd(logic o, logic [3:0] a, logic [3:0] b, logic [3:0] d);
    int n0;
    op = o; addr_a = a; addr_b = b; wdata = d;
    expect_cmd(o, a, b, d);
    n0 = n_done;
    press(10);
    wait_done(n0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, t;
    logic o;
    logic [3:0] a, b, d, old;
    for (int i = 0; i < 16; i++) begin rf_ref[i] = 0; rf_mon[i] = 0; end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn = ~btn;
      chk("rst_sw", sw_out, 0);
      chk("rst_strobes", {strb_we, strb_wd, strb_wr, strb_rr2, strb_rr1}, 0);
      chk("rst_busy_done", {busy, done}, 0);
    end
    btn = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (10) @(posedge clk);
    chk("idle_busy", busy, 0);

    run_cmd(0, 4'd3, 4'd12, 4'd0);
    run_cmd(1, 4'd5, 4'd0, 4'd9);
    chk("rf5", rf_mon[5], 9);

    // bounce shorter than the debounce window, then a long hold
    op = 0; addr_a = 1; addr_b = 2;
    expect_cmd(0, 4'd1, 4'd2, 4'd0);
    n0 = n_done;
    for (int p = 1; p <= 3; p++) begin
      @(posedge clk); #1 btn = 1;
      repeat (p) @(posedge clk);
      #1 btn = 0;
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1 btn = 1;
    repeat (50) @(posedge clk);
    #1 btn = 0;
    repeat (10) @(posedge clk);
    chk("bounce_one_cmd", n_done - n0, 1);
    n0 = n_done;
    run_cmd(0, 4'd1, 4'd2, 4'd0);
    repeat (30) @(posedge clk);
    chk("repress_one_cmd", n_done - n0, 1);

    // press while busy, switches changed mid-write
    op = 1; addr_a = 7; wdata = 4'hA;
    expect_cmd(1, 4'd7, 4'd0, 4'hA);
    n0 = n_done;
    @(posedge clk); #1 btn = 1;
    t = 0;
    while (!busy && t < 50) begin @(posedge clk); #1 t++; end
    chk("busy_seen", busy, 1);
    btn = 0; addr_a = 3; wdata = 4'h4; addr_b = 4'h6;
    repeat (6) @(posedge clk);
    #1 btn = 1;
    repeat (7) @(posedge clk);
    #1 chk("second_press_in_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1 btn = 0;
    wait_done(n0);
    repeat (40) @(posedge clk);
    chk("busy_press_one_done", n_done - n0, 1);
    chk("rf7", rf_mon[7], 4'hA);
    chk("rf3_untouched", rf_mon[3], rf_ref[3]);

    for (int i = 0; i < 10; i++) begin
      o = 1'($urandom_range(0, 1));
      a = 4'($urandom); b = 4'($urandom); d = 4'($urandom);
      run_cmd(o, a, b, d);
      if (o) chk("rf_rand", rf_mon[a], rf_ref[a]);
    end

    // reset during the write-data strobe
    op = 1; addr_a = 9; wdata = 4'h6;
    old = rf_ref[9];
    expect_cmd(1, 4'd9, 4'd0, 4'h6);
    @(posedge clk); #1 btn = 1;
    t = 0;
    while (!strb_wd && t < 100) begin @(posedge clk); #1 t++; end
    chk("wd_seen", strb_wd, 1);
    @(posedge clk); #2 rst_n = 0;
    #1 chk("rst_wd_drop", strb_wd, 0);
    chk("rst_busy_drop", busy, 0);
    chk("pending_we", exp_q.size(), 2);
    chk("pending_done", exp_done.size(), 1);
    exp_q.delete();
    exp_done.delete();
    rf_ref[9] = old;
    btn = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1;
    repeat (10) @(posedge clk);
    chk("rf9_no_write", rf_mon[9], old);
    run_cmd(1, 4'd9, 4'd0, 4'h6);
    chk("rf9_fresh", rf_mon[9], 6);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
